foc_loop_scheduler: RTL and testbench
=====================================

# foc_loop_scheduler

Per-PWM-period sequencer for the FOC control loop. On each PWM synchronisation pulse it waits a programmable sampling delay, then triggers the current-acquisition chain (ADC read, Clark, Park), the current PI stage and the SVPWM stage strictly in order, each on the previous stage's done pulse. It sits between the PWM timebase and the three stage enables. It adds a per-stage watchdog, overrun detection and a loop-cycle counter.

## Interface
Parameters:
- TRIG_DELAY, 10: clocks from accepted sync to the acquisition trigger (0..65535).
- TIMEOUT_CYCLES, 2000: maximum clocks a stage may take before it is declared hung (1..65535).

Ports:
- iClk  input  1  system clock; the block's only clock.
- iRst_n  input  1  reset; synchronous, active-low.
- iEn  input  1  loop enable, level.
- iPwm_sync  input  1  one-cycle pulse marking the PWM period reference point.
- iClear  input  1  one-cycle pulse; clears the sticky fault flags.
- oAdc_en  output  1  one-cycle pulse; starts current acquisition.
- iAdc_done  input  1  one-cycle pulse; Id/Iq valid.
- oPi_en  output  1  one-cycle pulse; starts the PI stage.
- iPi_done  input  1  one-cycle pulse.
- oSvpwm_en  output  1  one-cycle pulse; starts SVPWM.
- iSvpwm_done  input  1  one-cycle pulse.
- oBusy  output  1  high whenever state is not IDLE.
- oCycle_done  output  1  one-cycle pulse when a loop iteration completes.
- oCycle_cnt  output  16  number of completed iterations; wraps 0xFFFF to 0.
- oOverrun  output  1  sticky; a sync pulse arrived while busy.
- oTimeout  output  1  sticky; a stage watchdog expired.
- oFault_stage  output  2  stage of the first timeout: 0 none, 1 ADC, 2 PI, 3 SVPWM.

## Operation
- States: IDLE, DELAY, ADC, PI, SVPWM. All outputs are registered.
- Reset (iRst_n low at an edge): state returns to IDLE, all counters are zeroed, all outputs are 0. This applies mid-cycle as well; no enable pulse is emitted after reset.
- IDLE to DELAY on iPwm_sync and iEn. The delay counter loads TRIG_DELAY.
- DELAY: the counter decrements each clock. When it reads 0, the state moves to ADC and oAdc_en pulses.
- ADC to PI on iAdc_done, with an oPi_en pulse. PI to SVPWM on iPi_done, with an oSvpwm_en pulse.
- SVPWM to IDLE on iSvpwm_done. On that transition oCycle_done pulses and oCycle_cnt increments by 1.
- Done inputs that do not belong to the current state are ignored. This includes a done pulse in the wrong stage and any done pulse in IDLE or DELAY.
- Watchdog: a 16-bit counter clears on entry to ADC, PI or SVPWM and increments each clock in that stage. If it reaches TIMEOUT_CYCLES without the expected done:
  - the state moves to IDLE;
  - oTimeout is set;
  - oFault_stage latches the stage code, but only if it is currently 0 (first fault wins).
  - No further enables are emitted for that iteration.
- Done and watchdog expiry in the same clock: done wins, and no fault is recorded.
- Overrun: iPwm_sync while not in IDLE sets oOverrun. The sync pulse is dropped and the current iteration continues.
  - Exception: sync arriving in the same clock that SVPWM completes is accepted as a new start. The state goes directly to DELAY and no overrun is flagged.
- iEn low in any state: the state moves to IDLE on the next edge. No further enables are emitted, oCycle_cnt is unchanged, and the sticky flags are unaffected.
- iClear zeros oOverrun, oTimeout and oFault_stage. If a new fault occurs in the same clock as iClear, the fault wins.

## Timing
- Sync sampled at edge T (state IDLE, iEn high): oAdc_en is high during the cycle after edge T+TRIG_DELAY+1. With TRIG_DELAY=0 it is high the cycle after edge T+1.
- Done sampled at edge N: the next stage enable is high in the cycle after edge N, one clock later. This is the scheduler's entire per-stage latency.
- iSvpwm_done at edge N: oCycle_done, the new oCycle_cnt and oBusy=0 are all visible after edge N.
- Watchdog: if oX_en is high after edge E and no done arrives, the abort takes effect at edge E+TIMEOUT_CYCLES. oTimeout is visible after that edge.
- Each enable is exactly one clock wide. At most one enable is high in any clock.

## Test plan
- Nominal run, TRIG_DELAY=4, with the stubs answering done 3 clocks after each enable: sync -> oAdc_en 5 clocks after the sync edge, then oPi_en and oSvpwm_en each one clock after the preceding done; oCycle_cnt goes 0 to 1; oCycle_done is one pulse.
- TIMEOUT_CYCLES=100, PI stub never answers -> abort exactly 100 clocks after oPi_en; oTimeout=1 and oFault_stage=2; oSvpwm_en is never asserted; the next sync starts a clean iteration, and the flags stay set until iClear.
- Sync injected while in PI -> oOverrun=1; the iteration completes normally; exactly one oCycle_done.
- Sync coincident with iSvpwm_done -> no overrun; oAdc_en follows TRIG_DELAY+1 clocks later; oCycle_cnt has incremented.
- iEn dropped in ADC, then a late iAdc_done -> state is IDLE; no oPi_en is emitted; the count is unchanged. Separately, iRst_n held low for 1 clock in SVPWM -> all outputs are 0 and the count is 0.
- Preload 0xFFFF completed cycles (or force the counter), then run one more iteration -> oCycle_cnt wraps to 0.

Source files
------------

// File: rtl/foc_loop_scheduler_if.sv
// Handshake bundle between the FOC loop scheduler and its environment.
// The scheduler drives the stage enables and status; everything else is input.
interface foc_loop_scheduler_if;
    logic        iEn;
    logic        iPwm_sync;
    logic        iClear;
    logic        iAdc_done;
    logic        iPi_done;
    logic        iSvpwm_done;
    logic        oAdc_en;
    logic        oPi_en;
    logic        oSvpwm_en;
    logic        oBusy;
    logic        oCycle_done;
    logic [15:0] oCycle_cnt;
    logic        oOverrun;
    logic        oTimeout;
    logic [1:0]  oFault_stage;

    modport master (
        input  iEn,
        input  iPwm_sync,
        input  iClear,
        input  iAdc_done,
        input  iPi_done,
        input  iSvpwm_done,
        output oAdc_en,
        output oPi_en,
        output oSvpwm_en,
        output oBusy,
        output oCycle_done,
        output oCycle_cnt,
        output oOverrun,
        output oTimeout,
        output oFault_stage
    );

    modport slave (
        output iEn,
        output iPwm_sync,
        output iClear,
        output iAdc_done,
        output iPi_done,
        output iSvpwm_done,
        input  oAdc_en,
        input  oPi_en,
        input  oSvpwm_en,
        input  oBusy,
        input  oCycle_done,
        input  oCycle_cnt,
        input  oOverrun,
        input  oTimeout,
        input  oFault_stage
    );
endinterface

// File: rtl/foc_loop_scheduler.sv
// Per-PWM-period FOC loop sequencer: delayed ADC trigger, then PI and SVPWM,
// with a per-stage watchdog, sticky overrun/timeout flags and a cycle counter.
module foc_loop_scheduler #(
    parameter int unsigned TRIG_DELAY     = 10,
    parameter int unsigned TIMEOUT_CYCLES = 2000
) (
    input logic iClk,
    input logic iRst_n,
    foc_loop_scheduler_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        ADC,
        PI,
        SVPWM
    } state_t;

    localparam logic [15:0] DLY_LOAD = 16'(TRIG_DELAY);
    localparam logic [15:0] WD_LAST  = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_nx;
    logic [15:0] dly;
    logic [15:0] dly_nx;
    logic [15:0] wd;
    logic [15:0] wd_nx;
    logic        adc_en_nx;
    logic        pi_en_nx;
    logic        svpwm_en_nx;
    logic        cycle_done_nx;
    logic        abort;
    logic [1:0]  abort_code;
    logic        expire;
    logic        sync_busy;
    logic        overrun_nx;
    logic        timeout_nx;
    logic [1:0]  fault_keep;
    logic [1:0]  fault_nx;

    // wd holds clocks already spent in the stage; the abort edge is the
    // TIMEOUT_CYCLES-th one after entry
    assign expire = (wd == WD_LAST);

    // a sync coinciding with SVPWM completion is a restart, not an overrun
    assign sync_busy = bus.iPwm_sync
                    && (state != IDLE)
                    && !(state == SVPWM && bus.iSvpwm_done);

    always_comb begin
        state_nx      = state;
        dly_nx        = dly;
        wd_nx         = '0;
        adc_en_nx     = 1'b0;
        pi_en_nx      = 1'b0;
        svpwm_en_nx   = 1'b0;
        cycle_done_nx = 1'b0;
        abort         = 1'b0;
        abort_code    = 2'd0;

        unique case (state)
            IDLE: begin
                if (bus.iPwm_sync) begin
                    state_nx = DELAY;
                    dly_nx   = DLY_LOAD;
                end
            end
            DELAY: begin
                if (dly == 16'd0) begin
                    state_nx  = ADC;
                    adc_en_nx = 1'b1;
                end else begin
                    dly_nx = dly - 16'd1;
                end
            end
            ADC: begin
                if (bus.iAdc_done) begin
                    state_nx = PI;
                    pi_en_nx = 1'b1;
                end else if (expire) begin
                    state_nx   = IDLE;
                    abort      = 1'b1;
                    abort_code = 2'd1;
                end else begin
                    wd_nx = wd + 16'd1;
                end
            end
            PI: begin
                if (bus.iPi_done) begin
                    state_nx    = SVPWM;
                    svpwm_en_nx = 1'b1;
                end else if (expire) begin
                    state_nx   = IDLE;
                    abort      = 1'b1;
                    abort_code = 2'd2;
                end else begin
                    wd_nx = wd + 16'd1;
                end
            end
            SVPWM: begin
                if (bus.iSvpwm_done) begin
                    cycle_done_nx = 1'b1;
                    if (bus.iPwm_sync) begin
                        state_nx = DELAY;
                        dly_nx   = DLY_LOAD;
                    end else begin
                        state_nx = IDLE;
                    end
                end else if (expire) begin
                    state_nx   = IDLE;
                    abort      = 1'b1;
                    abort_code = 2'd3;
                end else begin
                    wd_nx = wd + 16'd1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // disable overrides everything: no enables, no count, no fault
        if (!bus.iEn) begin
            state_nx      = IDLE;
            adc_en_nx     = 1'b0;
            pi_en_nx      = 1'b0;
            svpwm_en_nx   = 1'b0;
            cycle_done_nx = 1'b0;
            abort         = 1'b0;
            abort_code    = 2'd0;
        end
    end

    always_comb begin
        overrun_nx = (bus.oOverrun && !bus.iClear) || sync_busy;
        timeout_nx = (bus.oTimeout && !bus.iClear) || abort;
        fault_keep = bus.iClear ? 2'd0 : bus.oFault_stage;
        fault_nx   = fault_keep;
        if (abort && fault_keep == 2'd0) begin
            fault_nx = abort_code;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state            <= IDLE;
            dly              <= '0;
            wd               <= '0;
            bus.oAdc_en      <= 1'b0;
            bus.oPi_en       <= 1'b0;
            bus.oSvpwm_en    <= 1'b0;
            bus.oBusy        <= 1'b0;
            bus.oCycle_done  <= 1'b0;
            bus.oCycle_cnt   <= '0;
            bus.oOverrun     <= 1'b0;
            bus.oTimeout     <= 1'b0;
            bus.oFault_stage <= 2'd0;
        end else begin
            state            <= state_nx;
            dly              <= dly_nx;
            wd               <= wd_nx;
            bus.oAdc_en      <= adc_en_nx;
            bus.oPi_en       <= pi_en_nx;
            bus.oSvpwm_en    <= svpwm_en_nx;
            bus.oBusy        <= (state_nx != IDLE);
            bus.oCycle_done  <= cycle_done_nx;
            if (cycle_done_nx) begin
                bus.oCycle_cnt <= bus.oCycle_cnt + 16'd1;
            end
            bus.oOverrun     <= overrun_nx;
            bus.oTimeout     <= timeout_nx;
            bus.oFault_stage <= fault_nx;
        end
    end

endmodule

// File: tb/tb_foc_loop_scheduler.sv
// Bench for foc_loop_scheduler: directed scenarios plus randomized traffic,
// all checked each cycle against a timestamp-based behavioural model.
module tb_foc_loop_scheduler;

    localparam int D  = 4;
    localparam int TO = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    foc_loop_scheduler_if sif ();

    foc_loop_scheduler #(
        .TRIG_DELAY     (D),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .bus    (sif.master)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // model: stage 0 idle, 1 waiting delay, 2 adc, 3 pi, 4 svpwm
    int          m_stage = 0;
    int          m_t0 = 0;
    logic        m_adc = 0, m_pi = 0, m_sv = 0, m_done = 0;
    logic        m_ov = 0, m_to = 0;
    logic [1:0]  m_fs = 0;
    logic [15:0] m_cnt = 0;

    // stubs and event log: 0 adc, 1 pi, 2 sv, 3 cycle_done, 4 timeout rise
    int lat[3] = '{3, 3, 3};
    int cd[3]  = '{0, 0, 0};
    bit rnd = 0;
    bit sync_on_sv = 0;
    int n_ev[5] = '{0, 0, 0, 0, 0};
    int t_ev[5] = '{0, 0, 0, 0, 0};
    logic to_prev = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic done_of(input int st);
        case (st)
            2: return sif.iAdc_done;
            3: return sif.iPi_done;
            4: return sif.iSvpwm_done;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_step();
        logic       ov_hit;
        logic       fault;
        logic [1:0] code;
        m_adc = 0; m_pi = 0; m_sv = 0; m_done = 0;
        fault = 0; code = 0;
        if (!rst_n) begin
            m_stage = 0; m_cnt = 0;
            m_ov = 0; m_to = 0; m_fs = 0;
            return;
        end
        ov_hit = sif.iPwm_sync && m_stage != 0
              && !(m_stage == 4 && sif.iSvpwm_done);
        if (!sif.iEn) begin
            m_stage = 0;
        end else if (m_stage == 0) begin
            if (sif.iPwm_sync) begin m_stage = 1; m_t0 = cyc; end
        end else if (m_stage == 1) begin
            if (cyc - m_t0 == D + 1) begin
                m_stage = 2; m_t0 = cyc; m_adc = 1;
            end
        end else if (done_of(m_stage)) begin
            if (m_stage == 2) m_pi = 1;
            if (m_stage == 3) m_sv = 1;
            if (m_stage == 4) begin
                m_done = 1;
                m_cnt = m_cnt + 16'd1;
                m_stage = sif.iPwm_sync ? 1 : 0;
            end else begin
                m_stage++;
            end
            m_t0 = cyc;
        end else if (cyc - m_t0 == TO) begin
            fault = 1;
            code = 2'(m_stage - 1);
            m_stage = 0;
        end
        if (sif.iClear) begin m_ov = 0; m_to = 0; m_fs = 0; end
        if (ov_hit) m_ov = 1;
        if (fault) begin
            m_to = 1;
            if (m_fs == 0) m_fs = code;
        end
    endtask

    task automatic tick();
        logic [24:0] got;
        logic [24:0] exp;
        logic [2:0]  fire;
        @(negedge clk);
        cyc++;
        model_step();
        got = {sif.oAdc_en, sif.oPi_en, sif.oSvpwm_en, sif.oBusy,
               sif.oCycle_done, sif.oOverrun, sif.oTimeout,
               sif.oFault_stage, sif.oCycle_cnt};
        exp = {m_adc, m_pi, m_sv, logic'(m_stage != 0),
               m_done, m_ov, m_to, m_fs, m_cnt};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL model cyc %0d: dut %b_%h model %b_%h",
                     cyc, got[24:16], got[15:0], exp[24:16], exp[15:0]);
        end
        if (sif.oAdc_en)     begin n_ev[0]++; t_ev[0] = cyc; end
        if (sif.oPi_en)      begin n_ev[1]++; t_ev[1] = cyc; end
        if (sif.oSvpwm_en)   begin n_ev[2]++; t_ev[2] = cyc; end
        if (sif.oCycle_done) begin n_ev[3]++; t_ev[3] = cyc; end
        if (sif.oTimeout && !to_prev) begin n_ev[4]++; t_ev[4] = cyc; end
        to_prev = sif.oTimeout;
        // stubs: done is sampled lat edges after the enable edge
        for (int k = 0; k < 3; k++) begin
            if ((k == 0 && sif.oAdc_en) || (k == 1 && sif.oPi_en)
                || (k == 2 && sif.oSvpwm_en)) begin
                if (rnd) cd[k] = ($urandom_range(0, 19) == 0)
                                 ? 0 : int'($urandom_range(1, 8));
                else cd[k] = lat[k];
            end
        end
        fire = 0;
        for (int k = 0; k < 3; k++) begin
            if (cd[k] > 0) begin
                cd[k]--;
                if (cd[k] == 0) fire[k] = 1;
            end
        end
        sif.iAdc_done   = fire[0];
        sif.iPi_done    = fire[1];
        sif.iSvpwm_done = fire[2];
        sif.iClear      = 0;
        sif.iPwm_sync   = fire[2] && sync_on_sv;
    endtask

    task automatic wait_ev(input int which, input int limit, input string name);
        int base;
        int i;
        base = n_ev[which];
        i = 0;
        while (n_ev[which] == base && i < limit) begin
            tick();
            i++;
        end
        if (n_ev[which] == base) begin
            tests++;
            fails++;
            $display("FAIL %s: no event after %0d cycles", name, limit);
        end
    endtask

    task automatic sync_pulse(output int ts);
        sif.iPwm_sync = 1;
        tick();
        ts = cyc;
    endtask

    initial begin
        int ts;
        int td;
        int base;
        sif.iEn = 0; sif.iPwm_sync = 0; sif.iClear = 0;
        sif.iAdc_done = 0; sif.iPi_done = 0; sif.iSvpwm_done = 0;
        repeat (3) tick();
        rst_n = 1;
        sif.iEn = 1;
        tick();
        check("reset_cnt", sif.oCycle_cnt, 0);
        check("reset_busy", sif.oBusy, 0);
        check("reset_flags", {sif.oOverrun, sif.oTimeout, sif.oFault_stage}, 0);

        // nominal iteration
        lat = '{3, 3, 3};
        sync_pulse(ts);
        wait_ev(3, 100, "nominal_done");
        check("nom_adc_lat", t_ev[0] - ts, 5);
        check("nom_pi_lat", t_ev[1] - t_ev[0], 3);
        check("nom_sv_lat", t_ev[2] - t_ev[1], 3);
        check("nom_done_lat", t_ev[3] - t_ev[2], 3);
        check("nom_cnt", sif.oCycle_cnt, 1);
        check("nom_done_pulses", n_ev[3], 1);

        // PI never answers
        lat = '{2, 0, 3};
        base = n_ev[2];
        sync_pulse(ts);
        wait_ev(4, 300, "timeout_rise");
        check("to_abort_lat", t_ev[4] - t_ev[1], 100);
        check("to_stage", sif.oFault_stage, 2);
        check("to_busy", sif.oBusy, 0);
        check("to_no_sv", n_ev[2] - base, 0);
        lat = '{2, 3, 3};
        sync_pulse(ts);
        wait_ev(3, 100, "post_timeout_done");
        check("post_to_adc_lat", t_ev[0] - ts, 5);
        check("post_to_cnt", sif.oCycle_cnt, 2);
        check("post_to_sticky", {sif.oTimeout, sif.oFault_stage}, 3'b110);
        sif.iClear = 1;
        tick();
        check("clear_flags", {sif.oTimeout, sif.oFault_stage}, 0);

        // overrun during PI
        lat = '{2, 10, 2};
        base = n_ev[3];
        sync_pulse(ts);
        wait_ev(1, 50, "ovr_pi_en");
        repeat (3) tick();
        sif.iPwm_sync = 1;
        tick();
        check("ovr_flag", sif.oOverrun, 1);
        wait_ev(3, 100, "ovr_done");
        repeat (20) tick();
        check("ovr_one_done", n_ev[3] - base, 1);
        check("ovr_cnt", sif.oCycle_cnt, 3);
        check("ovr_idle", sif.oBusy, 0);
        sif.iClear = 1;
        tick();

        // sync coincident with SVPWM done
        lat = '{2, 2, 4};
        sync_on_sv = 1;
        sync_pulse(ts);
        wait_ev(3, 100, "coinc_done");
        sync_on_sv = 0;
        td = t_ev[3];
        check("coinc_no_ovr", sif.oOverrun, 0);
        check("coinc_cnt", sif.oCycle_cnt, 4);
        check("coinc_busy", sif.oBusy, 1);
        wait_ev(0, 50, "coinc_adc");
        check("coinc_adc_lat", t_ev[0] - td, 5);
        wait_ev(3, 100, "coinc_second_done");
        check("coinc_cnt2", sif.oCycle_cnt, 5);

        // enable dropped in ADC, late done ignored
        lat = '{0, 2, 2};
        base = n_ev[1];
        sync_pulse(ts);
        wait_ev(0, 50, "endrop_adc");
        sif.iEn = 0;
        tick();
        sif.iEn = 1;
        repeat (2) tick();
        sif.iAdc_done = 1;
        repeat (10) tick();
        check("endrop_no_pi", n_ev[1] - base, 0);
        check("endrop_idle", sif.oBusy, 0);
        check("endrop_cnt", sif.oCycle_cnt, 5);

        // reset while in SVPWM
        lat = '{2, 2, 0};
        sync_pulse(ts);
        wait_ev(2, 50, "rst_sv_en");
        base = n_ev[0] + n_ev[1] + n_ev[2];
        rst_n = 0;
        tick();
        rst_n = 1;
        check("rst_outputs",
              {sif.oAdc_en, sif.oPi_en, sif.oSvpwm_en, sif.oBusy,
               sif.oCycle_done, sif.oOverrun, sif.oTimeout,
               sif.oFault_stage, sif.oCycle_cnt}, 0);
        repeat (10) tick();
        check("rst_no_en", n_ev[0] + n_ev[1] + n_ev[2] - base, 0);

        // counter wrap from preloaded 0xFFFF
        lat = '{2, 2, 2};
        m_cnt = 16'hFFFF;
        force sif.oCycle_cnt = 16'hFFFF;
        tick();
        release sif.oCycle_cnt;
        tick();
        check("wrap_preload", sif.oCycle_cnt, 16'hFFFF);
        sync_pulse(ts);
        wait_ev(3, 100, "wrap_done");
        check("wrap_cnt", sif.oCycle_cnt, 0);

        // randomized traffic against the model
        rnd = 1;
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 999) >= 3);
            sif.iEn = ($urandom_range(0, 99) >= 2);
            if ($urandom_range(0, 99) < 4) sif.iPwm_sync = 1;
            if ($urandom_range(0, 99) < 1) sif.iClear = 1;
            if ($urandom_range(0, 199) < 1) sif.iAdc_done = 1;
            if ($urandom_range(0, 199) < 1) sif.iPi_done = 1;
            if ($urandom_range(0, 199) < 1) sif.iSvpwm_done = 1;
            tick();
        end
        rst_n = 1;
        sif.iEn = 0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
